// File: rtl/thor2022_ptg_cache_pkg.sv
// Shared types, state encodings and the PTE match rule for the PTG cache.
package thor2022_ptg_cache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned VPN_W  = 16;
    localparam int unsigned ASID_W = 10;
    localparam int unsigned PPN_W  = 33;

    typedef logic [ADDR_W-1:0] dadr_t;

    // 64-bit page table entry
    typedef struct packed {
        logic              v;
        logic              g;
        logic [2:0]        rwx;
        logic [ASID_W-1:0] asid;
        logic [VPN_W-1:0]  vpn;
        logic [PPN_W-1:0]  ppn;
    } pte_t;

    // Tag half of a cache entry; the group payload is sized by the cache instance
    typedef struct packed {
        logic  v;
        dadr_t dadr;
    } ptgc_tag_t;

    localparam logic [1:0] PTGC_IDLE = 2'd0;
    localparam logic [1:0] PTGC_TAG  = 2'd1;
    localparam logic [1:0] PTGC_SCAN = 2'd2;
    localparam logic [1:0] PTGC_DONE = 2'd3;

    // A PTE matches when valid, same vpn, and either global or same address space
    function automatic logic pte_match(input pte_t pte, input logic [VPN_W-1:0] vpn,
                                       input logic [ASID_W-1:0] asid);
        return pte.v && (pte.vpn == vpn) && (pte.g || (pte.asid == asid));
    endfunction

endpackage

// File: rtl/thor2022_ptg_cache_if.sv
// Request/response/fill/invalidate/statistics bundle of the PTG cache.
interface thor2022_ptg_cache_if #(
    parameter int unsigned PTE_PER_PTG = 8
);
    import thor2022_ptg_cache_pkg::*;

    localparam int unsigned IDX_W = (PTE_PER_PTG > 1) ? $clog2(PTE_PER_PTG) : 1;

    logic                          req_v_i;
    logic                          req_rdy_o;
    dadr_t                         req_dadr_i;
    logic [VPN_W-1:0]              req_vpn_i;
    logic [ASID_W-1:0]             req_asid_i;

    logic                          resp_v_o;
    logic                          resp_hit_o;
    logic                          resp_ptg_miss_o;
    pte_t                          resp_pte_o;
    logic [IDX_W-1:0]              resp_idx_o;

    logic                          fill_v_i;
    logic                          fill_rdy_o;
    dadr_t                         fill_dadr_i;
    pte_t [PTE_PER_PTG-1:0]        fill_ptg_i;

    logic                          inv_all_i;
    logic                          inv_v_i;
    dadr_t                         inv_dadr_i;

    logic [31:0]                   hit_cnt_o;
    logic [31:0]                   miss_cnt_o;

    modport master (
        output req_v_i, req_dadr_i, req_vpn_i, req_asid_i,
        output fill_v_i, fill_dadr_i, fill_ptg_i,
        output inv_all_i, inv_v_i, inv_dadr_i,
        input  req_rdy_o, resp_v_o, resp_hit_o, resp_ptg_miss_o, resp_pte_o, resp_idx_o,
        input  fill_rdy_o, hit_cnt_o, miss_cnt_o
    );

    modport slave (
        input  req_v_i, req_dadr_i, req_vpn_i, req_asid_i,
        input  fill_v_i, fill_dadr_i, fill_ptg_i,
        input  inv_all_i, inv_v_i, inv_dadr_i,
        output req_rdy_o, resp_v_o, resp_hit_o, resp_ptg_miss_o, resp_pte_o, resp_idx_o,
        output fill_rdy_o, hit_cnt_o, miss_cnt_o
    );

endinterface

// File: rtl/thor2022_ptg_scan.sv
// LANES-wide PTE matcher with lowest-lane priority.
module thor2022_ptg_scan
    import thor2022_ptg_cache_pkg::*;
#(
    parameter  int unsigned LANES  = 2,
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  pte_t [LANES-1:0]  ptes_i,
    input  logic [VPN_W-1:0]  vpn_i,
    input  logic [ASID_W-1:0] asid_i,
    output logic              found_c,
    output logic [LANE_W-1:0] lane_c,
    output pte_t              pte_c
);

    // Walk from the top lane down so the lowest matching lane is the one kept
    always_comb begin
        found_c = 1'b0;
        lane_c  = '0;
        pte_c   = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (pte_match(ptes_i[i], vpn_i, asid_i)) begin
                found_c = 1'b1;
                lane_c  = LANE_W'(i);
                pte_c   = ptes_i[i];
            end
        end
    end

endmodule

// File: rtl/thor2022_ptg_cache.sv
// Fully associative PTG cache: tag lookup, lane-wise PTE scan, round-robin refill,
// in-place update, invalidation and hit/miss statistics.
module thor2022_ptg_cache
    import thor2022_ptg_cache_pkg::*;
#(
    parameter int unsigned DEP         = 8,
    parameter int unsigned PTE_PER_PTG = 8,
    parameter int unsigned LANES       = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    thor2022_ptg_cache_if.slave    bus
);

    localparam int unsigned WAY_W  = $clog2(DEP);
    localparam int unsigned IDX_W  = (PTE_PER_PTG > 1) ? $clog2(PTE_PER_PTG) : 1;
    localparam int unsigned GRPS   = PTE_PER_PTG / LANES;
    localparam int unsigned CNT_W  = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef pte_t [PTE_PER_PTG-1:0] ptg_t;

    logic [1:0]        state_q, state_d;
    logic [DEP-1:0]    v_q;
    dadr_t             dadr_mem [DEP];
    ptg_t              ptg_mem  [DEP];
    logic [WAY_W-1:0]  rr_ptr_q;

    dadr_t             lk_dadr_q;
    logic [VPN_W-1:0]  lk_vpn_q;
    logic [ASID_W-1:0] lk_asid_q;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              res_hit_q,  res_hit_d;
    logic              res_miss_q, res_miss_d;
    pte_t              res_pte_q,  res_pte_d;
    logic [IDX_W-1:0]  res_idx_q,  res_idx_d;

    logic              req_fire_c, fill_fire_c;
    logic [DEP-1:0]    live_c;
    logic              lk_hit_c,   fill_hit_c;
    logic [WAY_W-1:0]  lk_way_c,   fill_match_c, fill_way_c;
    pte_t [LANES-1:0]  lanes_c;
    logic              scan_found_c;
    logic [LANE_W-1:0] scan_lane_c;
    pte_t              scan_pte_c;

    assign bus.req_rdy_o  = (state_q == PTGC_IDLE) && !bus.fill_v_i;
    assign bus.fill_rdy_o = (state_q == PTGC_IDLE);
    assign req_fire_c     = bus.req_v_i && bus.req_rdy_o;
    assign fill_fire_c    = bus.fill_v_i && bus.fill_rdy_o;
    assign fill_way_c     = fill_hit_c ? fill_match_c : rr_ptr_q;

    // Valid bits as they will stand after this cycle's invalidations
    always_comb begin
        live_c = '0;
        for (int i = 0; i < int'(DEP); i++) begin
            live_c[i] = v_q[i] && !bus.inv_all_i &&
                        !(bus.inv_v_i && (dadr_mem[i] == bus.inv_dadr_i));
        end
    end

    // Tag match of the pending lookup, lowest way first
    always_comb begin
        lk_hit_c = 1'b0;
        lk_way_c = '0;
        for (int i = int'(DEP) - 1; i >= 0; i--) begin
            if (live_c[i] && (dadr_mem[i] == lk_dadr_q)) begin
                lk_hit_c = 1'b1;
                lk_way_c = WAY_W'(i);
            end
        end
    end

    // Tag match of an incoming fill, decides in-place update versus refill
    always_comb begin
        fill_hit_c   = 1'b0;
        fill_match_c = '0;
        for (int i = int'(DEP) - 1; i >= 0; i--) begin
            if (v_q[i] && (dadr_mem[i] == bus.fill_dadr_i)) begin
                fill_hit_c   = 1'b1;
                fill_match_c = WAY_W'(i);
            end
        end
    end

    // Current group of lanes in the latched way
    always_comb begin
        lanes_c = ptg_mem[way_q][int'(cnt_q) * int'(LANES) +: LANES];
    end

    thor2022_ptg_scan #(.LANES(LANES)) u_scan (
        .ptes_i  (lanes_c),
        .vpn_i   (lk_vpn_q),
        .asid_i  (lk_asid_q),
        .found_c (scan_found_c),
        .lane_c  (scan_lane_c),
        .pte_c   (scan_pte_c)
    );

    // Next-state and lookup result logic
    always_comb begin
        state_d    = state_q;
        way_d      = way_q;
        cnt_d      = cnt_q;
        res_hit_d  = res_hit_q;
        res_miss_d = res_miss_q;
        res_pte_d  = res_pte_q;
        res_idx_d  = res_idx_q;
        case (state_q)
            PTGC_IDLE: begin
                if (req_fire_c) state_d = PTGC_TAG;
            end
            PTGC_TAG: begin
                if (lk_hit_c) begin
                    way_d   = lk_way_c;
                    cnt_d   = '0;
                    state_d = PTGC_SCAN;
                end else begin
                    res_hit_d  = 1'b0;
                    res_miss_d = 1'b1;
                    res_pte_d  = '0;
                    res_idx_d  = '0;
                    state_d    = PTGC_DONE;
                end
            end
            PTGC_SCAN: begin
                if (!live_c[way_q]) begin
                    // way was invalidated under the scan
                    res_hit_d  = 1'b0;
                    res_miss_d = 1'b1;
                    res_pte_d  = '0;
                    res_idx_d  = '0;
                    state_d    = PTGC_DONE;
                end else if (scan_found_c) begin
                    res_hit_d  = 1'b1;
                    res_miss_d = 1'b0;
                    res_pte_d  = scan_pte_c;
                    res_idx_d  = IDX_W'(int'(cnt_q) * int'(LANES)) + IDX_W'(scan_lane_c);
                    state_d    = PTGC_DONE;
                end else if (cnt_q == CNT_W'(GRPS - 1)) begin
                    res_hit_d  = 1'b0;
                    res_miss_d = 1'b0;
                    res_pte_d  = '0;
                    res_idx_d  = '0;
                    state_d    = PTGC_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PTGC_DONE: begin
                state_d = PTGC_IDLE;
            end
            default: begin
                state_d = PTGC_IDLE;
            end
        endcase
    end

    // State, latched request and lookup result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PTGC_IDLE;
            lk_dadr_q  <= '0;
            lk_vpn_q   <= '0;
            lk_asid_q  <= '0;
            way_q      <= '0;
            cnt_q      <= '0;
            res_hit_q  <= 1'b0;
            res_miss_q <= 1'b0;
            res_pte_q  <= '0;
            res_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            way_q      <= way_d;
            cnt_q      <= cnt_d;
            res_hit_q  <= res_hit_d;
            res_miss_q <= res_miss_d;
            res_pte_q  <= res_pte_d;
            res_idx_q  <= res_idx_d;
            if (req_fire_c) begin
                lk_dadr_q <= bus.req_dadr_i;
                lk_vpn_q  <= bus.req_vpn_i;
                lk_asid_q <= bus.req_asid_i;
            end
        end
    end

    // Response outputs and statistics, updated as DONE retires
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.resp_v_o        <= 1'b0;
            bus.resp_hit_o      <= 1'b0;
            bus.resp_ptg_miss_o <= 1'b0;
            bus.resp_pte_o      <= '0;
            bus.resp_idx_o      <= '0;
            bus.hit_cnt_o       <= '0;
            bus.miss_cnt_o      <= '0;
        end else begin
            bus.resp_v_o <= (state_q == PTGC_DONE);
            if (state_q == PTGC_DONE) begin
                bus.resp_hit_o      <= res_hit_q;
                bus.resp_ptg_miss_o <= res_miss_q;
                bus.resp_pte_o      <= res_pte_q;
                bus.resp_idx_o      <= res_idx_q;
                if (res_hit_q) bus.hit_cnt_o  <= bus.hit_cnt_o + 32'd1;
                else           bus.miss_cnt_o <= bus.miss_cnt_o + 32'd1;
            end
        end
    end

    // Valid bits and refill pointer; invalidation overrides a same-cycle refill
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q      <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (fill_fire_c && !fill_hit_c) begin
                v_q[rr_ptr_q] <= 1'b1;
                rr_ptr_q      <= rr_ptr_q + WAY_W'(1);
            end
            if (bus.inv_all_i) begin
                v_q      <= '0;
                rr_ptr_q <= '0;
            end else if (bus.inv_v_i) begin
                for (int i = 0; i < int'(DEP); i++) begin
                    if (v_q[i] && (dadr_mem[i] == bus.inv_dadr_i)) v_q[i] <= 1'b0;
                end
            end
        end
    end

    // Tag and group storage, qualified by v_q so no reset is needed
    always_ff @(posedge clk_i) begin
        if (fill_fire_c) begin
            dadr_mem[fill_way_c] <= bus.fill_dadr_i;
            ptg_mem[fill_way_c]  <= bus.fill_ptg_i;
        end
    end

endmodule

// File: tb/tb_thor2022_ptg_cache.sv
// Directed, table-driven bench for the PTG cache (DEP=8, PTE_PER_PTG=8, LANES=2).
module tb_thor2022_ptg_cache;
    import thor2022_ptg_cache_pkg::*;

    typedef pte_t [7:0] ptg_t;

    typedef struct {
        logic [31:0] dadr;
        logic [15:0] vpn;
        logic [9:0]  asid;
        logic        hit;
        logic        miss;
        logic [2:0]  idx;
        int          lat;
        pte_t        pte;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   exp_hit_cnt;
    int   exp_miss_cnt;

    thor2022_ptg_cache_if #(.PTE_PER_PTG(8)) bus ();

    thor2022_ptg_cache #(.DEP(8), .PTE_PER_PTG(8), .LANES(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pte_t mk_pte(input logic [15:0] vpn, input logic [9:0] asid,
                                    input logic g, input logic [32:0] ppn);
        pte_t p;
        p.v = 1'b1; p.g = g; p.rwx = 3'b101; p.asid = asid; p.vpn = vpn; p.ppn = ppn;
        return p;
    endfunction

    function automatic vec_t mk_vec(input logic [31:0] dadr, input logic [15:0] vpn,
                                    input logic [9:0] asid, input logic hit, input logic miss,
                                    input logic [2:0] idx, input int lat, input pte_t pte);
        vec_t v;
        v.dadr = dadr; v.vpn = vpn; v.asid = asid; v.hit = hit; v.miss = miss;
        v.idx = idx; v.lat = lat; v.pte = pte;
        return v;
    endfunction

    task automatic do_fill(input logic [31:0] dadr, input ptg_t ptg);
        int n;
        bus.fill_v_i = 1'b1; bus.fill_dadr_i = dadr; bus.fill_ptg_i = ptg;
        #1;
        n = 0;
        while (!bus.fill_rdy_o && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.fill_v_i = 1'b0;
    endtask

    task automatic pulse_inv(input logic all, input logic [31:0] dadr);
        bus.inv_all_i = all; bus.inv_v_i = !all; bus.inv_dadr_i = dadr;
        @(posedge clk); #1;
        bus.inv_all_i = 1'b0; bus.inv_v_i = 1'b0;
    endtask

    task automatic wait_resp(output int cyc, output logic seen);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            seen = bus.resp_v_o;
        end
    endtask

    task automatic run_lookup(input string tag, input logic [31:0] dadr, input logic [15:0] vpn,
                              input logic [9:0] asid, input logic e_hit, input logic e_miss,
                              input logic [2:0] e_idx, input pte_t e_pte, input int e_lat);
        int   n;
        int   cyc;
        logic seen;
        bus.req_v_i = 1'b1; bus.req_dadr_i = dadr; bus.req_vpn_i = vpn; bus.req_asid_i = asid;
        #1;
        n = 0;
        while (!bus.req_rdy_o && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.req_v_i = 1'b0;
        wait_resp(cyc, seen);
        chk({tag, " resp_v"}, 64'(seen), 64'(1));
        chk({tag, " hit"}, 64'(bus.resp_hit_o), 64'(e_hit));
        chk({tag, " ptg_miss"}, 64'(bus.resp_ptg_miss_o), 64'(e_miss));
        chk({tag, " idx"}, 64'(bus.resp_idx_o), 64'(e_idx));
        chk({tag, " pte"}, bus.resp_pte_o, e_pte);
        if (e_lat != 0) chk({tag, " latency"}, 64'(cyc), 64'(e_lat));
        if (e_hit) exp_hit_cnt++;
        else       exp_miss_cnt++;
        @(posedge clk); #1;
        chk({tag, " pulse"}, 64'(bus.resp_v_o), 64'(0));
        chk({tag, " hold"}, 64'(bus.resp_hit_o), 64'(e_hit));
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, " hit_cnt"}, 64'(bus.hit_cnt_o), 64'(exp_hit_cnt));
        chk({tag, " miss_cnt"}, 64'(bus.miss_cnt_o), 64'(exp_miss_cnt));
    endtask

    initial begin
        ptg_t grp_a, grp_a_g, grp_b, grp_c, grp_k;
        pte_t decoy;
        vec_t vecs[9];
        int   cyc;
        logic seen;

        n_chk = 0; n_fail = 0; exp_hit_cnt = 0; exp_miss_cnt = 0;
        rst_n = 1'b0;
        bus.req_v_i = 1'b0; bus.req_dadr_i = '0; bus.req_vpn_i = '0; bus.req_asid_i = '0;
        bus.fill_v_i = 1'b0; bus.fill_dadr_i = '0; bus.fill_ptg_i = '0;
        bus.inv_all_i = 1'b0; bus.inv_v_i = 1'b0; bus.inv_dadr_i = '0;

        grp_a = '0;
        grp_a[0] = mk_pte(16'h0010, 10'd3, 1'b0, 33'h100);
        grp_a[1] = mk_pte(16'h0020, 10'd7, 1'b1, 33'h101);
        decoy = mk_pte(16'h0042, 10'd3, 1'b0, 33'h102);
        decoy.v = 1'b0;
        grp_a[2] = decoy;
        grp_a[5] = mk_pte(16'h0042, 10'd3, 1'b0, 33'h105);
        grp_a[6] = mk_pte(16'h0042, 10'd3, 1'b0, 33'h106);
        grp_a[7] = mk_pte(16'h0077, 10'd9, 1'b0, 33'h107);
        grp_a_g = grp_a;
        grp_a_g[5] = mk_pte(16'h0042, 10'd3, 1'b1, 33'h105);
        grp_b = '0;
        grp_b[0] = mk_pte(16'h0042, 10'd3, 1'b0, 33'h200);
        grp_b[3] = mk_pte(16'h0099, 10'd1, 1'b0, 33'h203);
        grp_c = '0;
        grp_c[2] = mk_pte(16'h0123, 10'd2, 1'b0, 33'h702);

        vecs[0] = mk_vec(32'h1000, 16'h0042, 10'd3, 1'b1, 1'b0, 3'd5, 5, grp_a[5]);
        vecs[1] = mk_vec(32'h1000, 16'h0042, 10'd4, 1'b0, 1'b0, 3'd0, 6, '0);
        vecs[2] = mk_vec(32'h1000, 16'h0010, 10'd3, 1'b1, 1'b0, 3'd0, 3, grp_a[0]);
        vecs[3] = mk_vec(32'h1000, 16'h0020, 10'd5, 1'b1, 1'b0, 3'd1, 3, grp_a[1]);
        vecs[4] = mk_vec(32'h1000, 16'h0077, 10'd9, 1'b1, 1'b0, 3'd7, 6, grp_a[7]);
        vecs[5] = mk_vec(32'h1000, 16'h0010, 10'd4, 1'b0, 1'b0, 3'd0, 6, '0);
        vecs[6] = mk_vec(32'h2000, 16'h0042, 10'd3, 1'b1, 1'b0, 3'd0, 3, grp_b[0]);
        vecs[7] = mk_vec(32'h2000, 16'h0099, 10'd1, 1'b1, 1'b0, 3'd3, 4, grp_b[3]);
        vecs[8] = mk_vec(32'h3000, 16'h0042, 10'd3, 1'b0, 1'b1, 3'd0, 2, '0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset req_rdy", 64'(bus.req_rdy_o), 64'(1));
        chk("reset fill_rdy", 64'(bus.fill_rdy_o), 64'(1));
        chk("reset resp_v", 64'(bus.resp_v_o), 64'(0));
        chk("reset resp_hit", 64'(bus.resp_hit_o), 64'(0));
        chk("reset resp_pte", bus.resp_pte_o, 64'(0));
        chk_cnt("reset");

        run_lookup("cold", 32'h1000, 16'h0042, 10'd3, 1'b0, 1'b1, 3'd0, '0, 2);
        chk("cold miss_cnt", 64'(bus.miss_cnt_o), 64'(1));

        do_fill(32'h1000, grp_a);
        do_fill(32'h2000, grp_b);
        for (int i = 0; i < 9; i++) begin
            run_lookup($sformatf("vec%0d", i), vecs[i].dadr, vecs[i].vpn, vecs[i].asid,
                       vecs[i].hit, vecs[i].miss, vecs[i].idx, vecs[i].pte, vecs[i].lat);
        end
        chk_cnt("table");

        do_fill(32'h1000, grp_a_g);
        run_lookup("global", 32'h1000, 16'h0042, 10'd4, 1'b1, 1'b0, 3'd5, grp_a_g[5], 5);

        // eviction order and in-place refill
        pulse_inv(1'b1, 32'h0);
        for (int k = 0; k < 9; k++) begin
            grp_k = '0;
            grp_k[0] = mk_pte(16'(16'h0300 + k), 10'd1, 1'b0, 33'(k));
            do_fill(32'(32'hA000 + k * 32'h100), grp_k);
        end
        run_lookup("evict k0", 32'hA000, 16'h0300, 10'd1, 1'b0, 1'b1, 3'd0, '0, 2);
        run_lookup("evict k1", 32'hA100, 16'h0301, 10'd1, 1'b1, 1'b0, 3'd0,
                   mk_pte(16'h0301, 10'd1, 1'b0, 33'd1), 3);
        grp_k = '0;
        grp_k[0] = mk_pte(16'h0400, 10'd1, 1'b0, 33'h400);
        do_fill(32'hB000, grp_k);
        run_lookup("rr1 k1", 32'hA100, 16'h0301, 10'd1, 1'b0, 1'b1, 3'd0, '0, 2);
        run_lookup("rr1 k2", 32'hA200, 16'h0302, 10'd1, 1'b1, 1'b0, 3'd0,
                   mk_pte(16'h0302, 10'd1, 1'b0, 33'd2), 3);
        grp_k = '0;
        grp_k[1] = mk_pte(16'h0303, 10'd1, 1'b0, 33'h333);
        do_fill(32'hA300, grp_k);
        grp_k = '0;
        grp_k[0] = mk_pte(16'h0401, 10'd1, 1'b0, 33'h401);
        do_fill(32'hB100, grp_k);
        run_lookup("rr2 k2", 32'hA200, 16'h0302, 10'd1, 1'b0, 1'b1, 3'd0, '0, 2);
        run_lookup("rr2 k3", 32'hA300, 16'h0303, 10'd1, 1'b1, 1'b0, 3'd1,
                   mk_pte(16'h0303, 10'd1, 1'b0, 33'h333), 3);
        run_lookup("rr2 k4", 32'hA400, 16'h0304, 10'd1, 1'b1, 1'b0, 3'd0,
                   mk_pte(16'h0304, 10'd1, 1'b0, 33'd4), 3);

        // inv_all while scanning a group that would hit at scan cycle 2
        do_fill(32'h1000, grp_a);
        bus.req_v_i = 1'b1; bus.req_dadr_i = 32'h1000; bus.req_vpn_i = 16'h0042; bus.req_asid_i = 10'd3;
        #1;
        @(posedge clk); #1;
        bus.req_v_i = 1'b0;
        @(posedge clk); #1;
        bus.inv_all_i = 1'b1;
        @(posedge clk); #1;
        bus.inv_all_i = 1'b0;
        wait_resp(cyc, seen);
        chk("invscan resp_v", 64'(seen), 64'(1));
        chk("invscan hit", 64'(bus.resp_hit_o), 64'(0));
        chk("invscan ptg_miss", 64'(bus.resp_ptg_miss_o), 64'(1));
        exp_miss_cnt++;
        @(posedge clk); #1;
        run_lookup("after invall A", 32'h1000, 16'h0042, 10'd3, 1'b0, 1'b1, 3'd0, '0, 2);
        run_lookup("after invall B", 32'hB100, 16'h0401, 10'd1, 1'b0, 1'b1, 3'd0, '0, 2);

        // single-entry invalidation, including one that misses
        do_fill(32'h5000, grp_b);
        do_fill(32'h6000, grp_b);
        pulse_inv(1'b0, 32'h5000);
        pulse_inv(1'b0, 32'h9999);
        run_lookup("inv hit", 32'h5000, 16'h0042, 10'd3, 1'b0, 1'b1, 3'd0, '0, 2);
        run_lookup("inv other", 32'h6000, 16'h0042, 10'd3, 1'b1, 1'b0, 3'd0, grp_b[0], 3);

        // fill and request in the same idle cycle: fill wins, request follows
        bus.fill_v_i = 1'b1; bus.fill_dadr_i = 32'h7000; bus.fill_ptg_i = grp_c;
        bus.req_v_i = 1'b1; bus.req_dadr_i = 32'h7000; bus.req_vpn_i = 16'h0123; bus.req_asid_i = 10'd2;
        #1;
        chk("collide req_rdy", 64'(bus.req_rdy_o), 64'(0));
        chk("collide fill_rdy", 64'(bus.fill_rdy_o), 64'(1));
        @(posedge clk); #1;
        bus.fill_v_i = 1'b0;
        run_lookup("collide", 32'h7000, 16'h0123, 10'd2, 1'b1, 1'b0, 3'd2, grp_c[2], 4);
        chk_cnt("final");

        // reset in the middle of a scan aborts without a response
        bus.req_v_i = 1'b1; bus.req_dadr_i = 32'h7000; bus.req_vpn_i = 16'h0123; bus.req_asid_i = 10'd2;
        #1;
        @(posedge clk); #1;
        bus.req_v_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("midrst resp_v", 64'(bus.resp_v_o), 64'(0));
        chk("midrst hit_cnt", 64'(bus.hit_cnt_o), 64'(0));
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | bus.resp_v_o;
        end
        chk("midrst no resp", 64'(seen), 64'(0));
        exp_hit_cnt = 0; exp_miss_cnt = 0;
        run_lookup("postrst", 32'h7000, 16'h0123, 10'd2, 1'b0, 1'b1, 3'd0, '0, 2);
        chk_cnt("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
